// File: rtl/eth_tx_data_pkg.sv
// Shared definitions for the RMII transmit path: control-FSM state encodings,
// line constants and CRC-32 parameters.
package eth_tx_data_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_PREAMBLE  = 4'd1,
      ST_SFD       = 4'd2,
      ST_DEST_ADDR = 4'd3,
      ST_SRC_ADDR  = 4'd4,
      ST_LEN_TYPE  = 4'd5,
      ST_DATA      = 4'd6,
      ST_PAD       = 4'd7,
      ST_FCS       = 4'd8
   } tx_state_e;

   localparam logic [1:0]  pPreamble_Dibit = 2'b01;
   localparam logic [1:0]  pSFD_Last_Dibit = 2'b11;
   localparam logic [31:0] pCrc_Init       = 32'hFFFF_FFFF;
   localparam logic [31:0] pCrc_Poly       = 32'hEDB8_8320;
   localparam logic [31:0] pCrc_Residue    = 32'hDEBB_20E3;
   localparam logic [4:0]  IDX_LAST        = 5'd23;

   // Dibit idx of a big-endian-byte field left-aligned in 48 bits; bytes go LSB first.
   function automatic logic [1:0] field_dibit(input logic [47:0] f, input logic [4:0] idx);
      logic [5:0] pos;
      pos = 6'd40 - {idx[4:2], 3'b000} + {3'b000, idx[1:0], 1'b0};
      return f[pos +: 2];
   endfunction

endpackage

// File: rtl/eth_tx_data_if.sv
// Control/header inputs from the tx control FSM and RMII pin outputs of the
// transmit datapath.
interface eth_tx_data_if;
   logic [3:0]  Tx_Ctrl_FSM_State;
   logic        Tx_En;
   logic        Crc_En;
   logic        Fifo_Rd;
   logic [7:0]  Fifo_Data;
   logic [47:0] Dest_Addr;
   logic [47:0] Src_Addr;
   logic [15:0] Len_Type;
   logic [1:0]  Eth_Txd;
   logic        Eth_Txen;
   logic [31:0] Crc_Val;

   modport master (
      output Tx_Ctrl_FSM_State, Tx_En, Crc_En, Fifo_Rd, Fifo_Data,
             Dest_Addr, Src_Addr, Len_Type,
      input  Eth_Txd, Eth_Txen, Crc_Val
   );

   modport slave (
      input  Tx_Ctrl_FSM_State, Tx_En, Crc_En, Fifo_Rd, Fifo_Data,
             Dest_Addr, Src_Addr, Len_Type,
      output Eth_Txd, Eth_Txen, Crc_Val
   );
endinterface

// File: rtl/eth_tx_data_crc32.sv
// Combinational CRC-32 step over one dibit (bit0 folded first); shared with RX.
module eth_crc32_dibit #(
   parameter logic [31:0] pCrc_Poly = 32'hEDB8_8320
) (
   input  logic [31:0] crc,
   input  logic [1:0]  d,
   output logic [31:0] crc_next
);
   logic [31:0] c1;

   always_comb begin
      c1       = {1'b0, crc[31:1]} ^ ((crc[0] ^ d[0]) ? pCrc_Poly : 32'd0);
      crc_next = {1'b0, c1[31:1]}  ^ ((c1[0]  ^ d[1]) ? pCrc_Poly : 32'd0);
   end
endmodule

// File: rtl/eth_tx_data.sv
// RMII transmit datapath: maps tx-control state, header fields and FIFO bytes
// onto registered TXD/TX_EN dibits and appends the CRC-32 FCS.
module eth_tx_data
   import eth_tx_data_pkg::*;
#(
   parameter logic [31:0] pCrc_Init = eth_tx_data_pkg::pCrc_Init,
   parameter logic [31:0] pCrc_Poly = eth_tx_data_pkg::pCrc_Poly
) (
   input logic         Clk,
   input logic         Rst,
   eth_tx_data_if.slave tx
);
   tx_state_e   st;
   logic [3:0]  state_q;
   logic [4:0]  idx_q, idx;
   logic        rd_q;
   logic [7:0]  sr_q, sr_nxt;
   logic [1:0]  dib;
   logic [31:0] crc_q, crc_nxt, crc_inv;
   logic        fold;

   assign st      = tx_state_e'(tx.Tx_Ctrl_FSM_State);
   assign crc_inv = ~crc_q;

   always_comb begin
      if (st == ST_IDLE || tx.Tx_Ctrl_FSM_State != state_q) idx = 5'd0;
      else if (idx_q == IDX_LAST)                            idx = 5'd0;
      else                                                   idx = idx_q + 5'd1;
   end

   // FIFO byte arrives the clk after Fifo_Rd: drive its first dibit at once and
   // park the rest in the shift reg; zeros shift in so an unreloaded byte ends in 00.
   always_comb begin
      dib    = 2'b00;
      sr_nxt = 8'h00;
      case (st)
         ST_PREAMBLE:  dib = pPreamble_Dibit;
         ST_SFD:       dib = (idx == 5'd3) ? pSFD_Last_Dibit : pPreamble_Dibit;
         ST_DEST_ADDR: dib = field_dibit(tx.Dest_Addr, idx);
         ST_SRC_ADDR:  dib = field_dibit(tx.Src_Addr, idx);
         ST_LEN_TYPE:  dib = field_dibit({tx.Len_Type, 32'h0}, idx);
         ST_DATA: begin
            if (rd_q) begin
               dib    = tx.Fifo_Data[1:0];
               sr_nxt = {2'b00, tx.Fifo_Data[7:2]};
            end else begin
               dib    = sr_q[1:0];
               sr_nxt = {2'b00, sr_q[7:2]};
            end
         end
         ST_FCS:       dib = crc_inv[{idx[3:0], 1'b0} +: 2];
         default:      dib = 2'b00;
      endcase
      if (!tx.Tx_En) dib = 2'b00;
   end

   assign fold = tx.Crc_En && (st == ST_DEST_ADDR || st == ST_SRC_ADDR ||
                               st == ST_LEN_TYPE  || st == ST_DATA     || st == ST_PAD);

   eth_crc32_dibit #(.pCrc_Poly(pCrc_Poly)) u_crc (
      .crc      (crc_q),
      .d        (dib),
      .crc_next (crc_nxt)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= 5'd0;
         rd_q        <= 1'b0;
         sr_q        <= 8'h00;
         crc_q       <= pCrc_Init;
         tx.Eth_Txd  <= 2'b00;
         tx.Eth_Txen <= 1'b0;
      end else begin
         state_q     <= tx.Tx_Ctrl_FSM_State;
         idx_q       <= idx;
         rd_q        <= tx.Fifo_Rd;
         sr_q        <= sr_nxt;
         if (st == ST_IDLE) crc_q <= pCrc_Init;
         else if (fold)     crc_q <= crc_nxt;
         tx.Eth_Txd  <= dib;
         tx.Eth_Txen <= tx.Tx_En;
      end
   end

   assign tx.Crc_Val = crc_q;
endmodule

// File: tb/tb_eth_tx_data.sv
// Scoreboard bench for eth_tx_data: frames built from byte lists, expected
// dibits queued per cycle and compared by an independent monitor.
module tb_eth_tx_data;
   import eth_tx_data_pkg::*;

   logic Clk = 1'b0;
   logic Rst;
   always #10 Clk = ~Clk;

   eth_tx_data_if tx();
   eth_tx_data dut (.Clk(Clk), .Rst(Rst), .tx(tx));

   typedef struct {
      int          due;
      logic [1:0]  txd;
      logic        txen;
      bit          chk_crc;
      logic [31:0] crc;
      bit          start;
      bit          body;
      bit          endf;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  rx_bytes[$];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ pCrc_Poly) : (r >> 1);
      return r;
   endfunction

   function automatic exp_t mk(input logic [1:0] txd, input logic txen, input bit chk,
                               input logic [31:0] crc, input bit start, input bit body,
                               input bit endf);
      exp_t e;
      e.due = 0; e.txd = txd; e.txen = txen; e.chk_crc = chk; e.crc = crc;
      e.start = start; e.body = body; e.endf = endf;
      return e;
   endfunction

   task automatic drive(input logic rst, input logic [3:0] st, input logic ten, input logic cen,
                        input logic rd, input logic [7:0] fd, input exp_t e);
      @(posedge Clk); #1;
      Rst = rst;
      tx.Tx_Ctrl_FSM_State = st;
      tx.Tx_En = ten; tx.Crc_En = cen; tx.Fifo_Rd = rd; tx.Fifo_Data = fd;
      e.due = cyc + 1;
      q.push_back(e);
   endtask

   task automatic idle_cycle();
      drive(0, ST_IDLE, 0, 0, 0, 8'($urandom), mk(2'b00, 0, 1, pCrc_Init, 0, 0, 0));
   endtask

   // mode 0: complete frame; 1: Tx_En dropped at DATA dibit 'at'; 2: Rst for 3 clk at 'at'
   task automatic send_frame(input logic [47:0] dest, input logic [47:0] src,
                             input logic [15:0] lt, input int n, input int mode, input int at);
      logic [7:0]  bb[$];
      logic [7:0]  pay[$];
      logic [7:0]  b;
      logic [31:0] crc, fcs;
      logic [3:0]  st;
      int          npad;
      tx.Dest_Addr = dest; tx.Src_Addr = src; tx.Len_Type = lt;
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      npad = (n < 46) ? 46 - n : 0;
      for (int i = 0; i < 6; i++) bb.push_back(dest[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) bb.push_back(src[47-8*i -: 8]);
      bb.push_back(lt[15:8]); bb.push_back(lt[7:0]);
      foreach (pay[i]) bb.push_back(pay[i]);
      for (int i = 0; i < npad; i++) bb.push_back(8'h00);
      crc = pCrc_Init;
      foreach (bb[i]) crc = crc_byte(crc, bb[i]);
      fcs = ~crc;

      idle_cycle(); idle_cycle();
      repeat (28) drive(0, ST_PREAMBLE, 1, 0, 0, 8'($urandom), mk(2'b01, 1, 0, 0, 0, 0, 0));
      for (int i = 0; i < 4; i++)
         drive(0, ST_SFD, 1, 0, 0, 8'($urandom), mk((i == 3) ? 2'b11 : 2'b01, 1, 0, 0, 0, 0, 0));
      for (int p = 0; p < 14; p++) begin
         st = (p < 6) ? ST_DEST_ADDR : (p < 12) ? ST_SRC_ADDR : ST_LEN_TYPE;
         b  = bb[p];
         for (int k = 0; k < 4; k++)
            drive(0, st, 1, 1, (p == 13 && k == 3), 8'($urandom),
                  mk(b[2*k +: 2], 1, 0, 0, (p == 0 && k == 0), 1, 0));
      end
      for (int j = 0; j < n; j++) begin
         b = pay[j];
         for (int k = 0; k < 4; k++) begin
            if (mode != 0 && 4*j + k == at) begin
               if (mode == 1) begin
                  drive(0, ST_DATA, 0, 1, 0, 8'($urandom), mk(2'b00, 0, 0, 0, 0, 0, 0));
               end else begin
                  repeat (3) drive(1, ST_DATA, 1, 1, 0, 8'($urandom), mk(2'b00, 0, 1, pCrc_Init, 0, 0, 0));
                  drive(0, ST_PREAMBLE, 1, 0, 0, 8'($urandom), mk(2'b01, 1, 1, pCrc_Init, 0, 0, 0));
               end
               idle_cycle();
               return;
            end
            drive(0, ST_DATA, 1, 1, (k == 3 && j < n-1), (k == 0) ? b : 8'($urandom),
                  mk(b[2*k +: 2], 1, 0, 0, 0, 1, 0));
         end
      end
      repeat (4*npad) drive(0, ST_PAD, 1, 1, 0, 8'($urandom), mk(2'b00, 1, 0, 0, 0, 1, 0));
      for (int i = 0; i < 16; i++)
         drive(0, ST_FCS, 1, 0, 0, 8'($urandom), mk(fcs[2*i +: 2], 1, 1, crc, 0, 1, (i == 15)));
      idle_cycle();
   endtask

   // Check value "123456789" folded as payload only; FCS must be the CRC-32 check word
   task automatic crc_vector();
      logic [71:0] s;
      logic [31:0] chk;
      logic [7:0]  b;
      s   = "123456789";
      chk = 32'hCBF4_3926;
      idle_cycle();
      drive(0, ST_IDLE, 0, 0, 1, 8'($urandom), mk(2'b00, 0, 1, pCrc_Init, 0, 0, 0));
      for (int j = 0; j < 9; j++) begin
         b = s[71-8*j -: 8];
         for (int k = 0; k < 4; k++)
            drive(0, ST_DATA, 1, 1, (k == 3 && j < 8), (k == 0) ? b : 8'($urandom),
                  mk(b[2*k +: 2], 1, 0, 0, (j == 0 && k == 0), 1, 0));
      end
      for (int i = 0; i < 16; i++)
         drive(0, ST_FCS, 1, 0, 0, 8'($urandom), mk(chk[2*i +: 2], 1, 1, 32'h340B_C6D9, 0, 1, (i == 15)));
      idle_cycle();
   endtask

   initial begin : monitor
      exp_t        e;
      logic [7:0]  cur;
      logic [31:0] r;
      int          k;
      cur = 8'h00; k = 0;
      forever begin
         @(negedge Clk);
         while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.due != cyc) begin
               errors++;
               $display("FAIL sched: item due %0d sampled at %0d", e.due, cyc);
            end
            checks++;
            if (tx.Eth_Txd !== e.txd) begin
               errors++;
               $display("FAIL txd @%0d: got %b want %b", cyc, tx.Eth_Txd, e.txd);
            end
            checks++;
            if (tx.Eth_Txen !== e.txen) begin
               errors++;
               $display("FAIL txen @%0d: got %b want %b", cyc, tx.Eth_Txen, e.txen);
            end
            if (e.chk_crc) begin
               checks++;
               if (tx.Crc_Val !== e.crc) begin
                  errors++;
                  $display("FAIL crc_val @%0d: got %h want %h", cyc, tx.Crc_Val, e.crc);
               end
            end
            if (e.start) begin rx_bytes.delete(); k = 0; cur = 8'h00; end
            if (e.body) begin
               cur[2*k +: 2] = tx.Eth_Txd;
               k++;
               if (k == 4) begin rx_bytes.push_back(cur); k = 0; cur = 8'h00; end
            end
            if (e.endf) begin
               r = pCrc_Init;
               foreach (rx_bytes[i]) r = crc_byte(r, rx_bytes[i]);
               checks++;
               if (r !== pCrc_Residue) begin
                  errors++;
                  $display("FAIL residue @%0d: got %h want %h", cyc, r, pCrc_Residue);
               end
            end
         end
      end
   end

   initial begin
      int n;
      Rst = 1'b1;
      tx.Tx_Ctrl_FSM_State = ST_IDLE; tx.Tx_En = 0; tx.Crc_En = 0; tx.Fifo_Rd = 0;
      tx.Fifo_Data = 0; tx.Dest_Addr = 0; tx.Src_Addr = 0; tx.Len_Type = 0;
      repeat (3) drive(1, ST_IDLE, 0, 0, 0, 8'h00, mk(2'b00, 0, 1, pCrc_Init, 0, 0, 0));

      send_frame(48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0800, 46, 0, 0);
      crc_vector();
      repeat (2) drive(0, 4'd12, 1, 0, 0, 8'($urandom), mk(2'b00, 1, 0, 0, 0, 0, 0));
      idle_cycle();
      repeat (4) begin
         n = $urandom_range(1, 60);
         send_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'($urandom), n, 0, 0);
      end
      n = $urandom_range(2, 50);
      send_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h0800, n, 1,
                 $urandom_range(1, 4*n-1));
      send_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h86DD, 20, 0, 0);
      n = $urandom_range(2, 50);
      send_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h0806, n, 2,
                 $urandom_range(1, 4*n-1));
      send_frame({16'($urandom), $urandom}, {16'($urandom), $urandom}, 16'h0800, 50, 0, 0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge Clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected items left, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
